// File: rtl/lpc_pkg.sv
// Shared LPC front-end definitions: FSM states, frame/order defaults
// and the sweep length helper used by the autocorrelation blocks.
package lpc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } lag_state_e;

  localparam int LPC_FRAME_LEN = 160;
  localparam int LPC_ORDER     = 10;

  function automatic int lpc_total_cycles(
    input int frame_len,
    input int order,
    input bit full
  );
    if (full)
      return (order + 1) * frame_len;
    return (order + 1) * frame_len - (order * (order + 1)) / 2;
  endfunction

endpackage

// File: rtl/autocorr_lag_counter.sv
// Sample index / lag counter for the autocorrelation sweep.
// AUTOCORR_FULL_SWEEP_EN starts every lag at n=0 instead of n=lag.
module autocorr_lag_counter
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = LPC_FRAME_LEN,
  parameter int ORDER     = LPC_ORDER,
  parameter int ADDR_W    = $clog2(FRAME_LEN),
  parameter int LAG_W     = $clog2(ORDER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] n_nxt_o,
  output logic [LAG_W-1:0]  lag_nxt_o,
  output logic              last_n_o,
  output logic              last_lag_o
);

  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [LAG_W-1:0]  L_LAST = LAG_W'(ORDER);

  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] n_d;
  logic [ADDR_W-1:0] nxt_start;
  logic [LAG_W-1:0]  lag_q;
  logic [LAG_W-1:0]  lag_d;
  logic [LAG_W-1:0]  lag_inc;

  assign last_n_o   = (n_q == N_LAST);
  assign last_lag_o = (lag_q == L_LAST);
  assign lag_inc    = lag_q + LAG_W'(1);

`ifdef AUTOCORR_FULL_SWEEP_EN
  assign nxt_start = '0;
`else
  assign nxt_start = ADDR_W'(lag_inc);
`endif

  always_comb begin
    n_d   = n_q;
    lag_d = lag_q;
    if (clear_i || load_i) begin
      n_d   = '0;
      lag_d = '0;
    end else if (adv_i) begin
      if (last_n_o) begin
        // Final lag wraps to zero so the counter idles clean.
        if (last_lag_o) begin
          n_d   = '0;
          lag_d = '0;
        end else begin
          n_d   = nxt_start;
          lag_d = lag_inc;
        end
      end else begin
        n_d = n_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q   <= '0;
      lag_q <= '0;
    end else begin
      n_q   <= n_d;
      lag_q <= lag_d;
    end
  end

  assign n_nxt_o   = n_d;
  assign lag_nxt_o = lag_d;

endmodule

// File: rtl/autocorr_lag_sequencer.sv
// LPC autocorrelation address/lag sequencer with start/done handshake.
// AUTOCORR_FULL_SWEEP_EN selects zero-padded full-frame lag sweeps.
module autocorr_lag_sequencer
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = LPC_FRAME_LEN,
  parameter int ORDER     = LPC_ORDER,
  parameter int ADDR_W    = $clog2(FRAME_LEN),
  parameter int LAG_W     = $clog2(ORDER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr_a,
  output logic [ADDR_W-1:0] raddr_b,
  output logic [LAG_W-1:0]  lag_idx,
  output logic              acc_clr,
  output logic              mac_valid,
  output logic [ORDER:0]    wsel
);

  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ORDER:0]    WS_ONE = {{ORDER{1'b0}}, 1'b1};

  lag_state_e state_q;
  lag_state_e state_d;

  logic              cnt_clr;
  logic              cnt_load;
  logic              cnt_adv;
  logic [ADDR_W-1:0] n_nxt;
  logic [LAG_W-1:0]  lag_nxt;
  logic              last_n;
  logic              last_lag;

  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [LAG_W-1:0]  lag_q, lag_d;
  logic              clr_q, clr_d;
  logic              vld_q, vld_d;
  logic [ORDER:0]    ws_q, ws_d;

  autocorr_lag_counter #(
    .FRAME_LEN(FRAME_LEN),
    .ORDER    (ORDER),
    .ADDR_W   (ADDR_W),
    .LAG_W    (LAG_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clr),
    .load_i    (cnt_load),
    .adv_i     (cnt_adv),
    .n_nxt_o   (n_nxt),
    .lag_nxt_o (lag_nxt),
    .last_n_o  (last_n),
    .last_lag_o(last_lag)
  );

  always_comb begin
    state_d  = state_q;
    cnt_clr  = abort;
    cnt_load = 1'b0;
    cnt_adv  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_RUN;
            cnt_load = 1'b1;
          end
        end
        S_RUN: begin
          if (!stall) begin
            cnt_adv = 1'b1;
            if (last_n && last_lag)
              state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output registers hold the product for the pair the counter moves to.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    ra_d    = '0;
    rb_d    = '0;
    lag_d   = '0;
    clr_d   = 1'b0;
    vld_d   = 1'b0;
    ws_d    = '0;
    if (busy_d) begin
      ra_d  = n_nxt;
      lag_d = lag_nxt;
      if (n_nxt == N_LAST)
        ws_d = WS_ONE << lag_nxt;
`ifdef AUTOCORR_FULL_SWEEP_EN
      clr_d = (n_nxt == '0);
      if (n_nxt >= ADDR_W'(lag_nxt)) begin
        vld_d = 1'b1;
        rb_d  = n_nxt - ADDR_W'(lag_nxt);
      end
`else
      clr_d = (n_nxt == ADDR_W'(lag_nxt));
      vld_d = 1'b1;
      rb_d  = n_nxt - ADDR_W'(lag_nxt);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      lag_q   <= '0;
      clr_q   <= 1'b0;
      vld_q   <= 1'b0;
      ws_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      lag_q   <= lag_d;
      clr_q   <= clr_d;
      vld_q   <= vld_d;
      ws_q    <= ws_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign raddr_a   = ra_q;
  assign raddr_b   = rb_q;
  assign lag_idx   = lag_q;
  // Strobes are masked while stalled; the held pair re-issues them.
  assign acc_clr   = clr_q & ~stall;
  assign mac_valid = vld_q & ~stall;
  assign wsel      = stall ? '0 : ws_q;

endmodule

// File: tb/tb_autocorr_lag_sequencer.sv
// Self-checking bench for autocorr_lag_sequencer: vector table,
// scoreboarded sweeps with random stall/start noise, abort and reset.
module tb_autocorr_lag_sequencer;
  import lpc_pkg::*;

`ifdef AUTOCORR_FULL_SWEEP_EN
  localparam int FL   = 16;
  localparam int ORD  = 3;
  localparam bit FULL = 1'b1;
`else
  localparam int FL   = 160;
  localparam int ORD  = 10;
  localparam bit FULL = 1'b0;
`endif
  localparam int AW    = $clog2(FL);
  localparam int LW    = $clog2(ORD + 1);
  localparam int LIMIT = 6000;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          stall;
  logic          ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic [LW-1:0] lag_idx;
  logic          acc_clr;
  logic          mac_valid;
  logic [ORD:0]  wsel;

  int nvec;
  int nmis;

  autocorr_lag_sequencer #(
    .FRAME_LEN(FL),
    .ORDER    (ORD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .stall    (stall),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .lag_idx  (lag_idx),
    .acc_clr  (acc_clr),
    .mac_valid(mac_valid),
    .wsel     (wsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int a;
    int b;
    int lag;
    bit clr;
    bit vld;
    int ws;
  } prod_t;

  typedef struct {
    bit s, ab, st;
    bit rdy, bsy, dn, vld, clr;
    int ra, rb, lg, ws;
  } vec_t;

  prod_t exp_q[$];
  vec_t  tv[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit s, input bit a, input bit st);
    start = s;
    abort = a;
    stall = st;
    @(negedge clk);
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ra"}, raddr_a, 0);
    chk({nm, "_rb"}, raddr_b, 0);
    chk({nm, "_lag"}, lag_idx, 0);
    chk({nm, "_clr"}, acc_clr, 0);
    chk({nm, "_vld"}, mac_valid, 0);
    chk({nm, "_wsel"}, wsel, 0);
  endtask

  // Expected product stream for one full sweep.
  function automatic void build_model();
    prod_t p;
    int    n0;
    exp_q.delete();
    for (int k = 0; k <= ORD; k++) begin
      n0 = FULL ? 0 : k;
      for (int n = n0; n < FL; n++) begin
        p.a   = n;
        p.vld = (n >= k);
        p.b   = p.vld ? n - k : 0;
        p.lag = k;
        p.clr = (n == n0);
        p.ws  = (n == FL - 1) ? (1 << k) : 0;
        exp_q.push_back(p);
      end
    end
  endfunction

  function automatic int find_idx(input int lag, input int n);
    foreach (exp_q[i])
      if (exp_q[i].lag == lag && exp_q[i].a == n)
        return i;
    return -1;
  endfunction

  function automatic int valid_total();
    int t = 0;
    for (int k = 0; k <= ORD; k++)
      t += FL - k;
    return t;
  endfunction

  task automatic run_sweep(input int stall_pct, input bit noise,
                           input int stall_idx, input int abort_idx);
    int    idx, cyc, act, vcnt, ccnt, wcnt, hold;
    bit    st, sn;
    prod_t e;
    idx = 0; cyc = 0; act = 0;
    vcnt = 0; ccnt = 0; wcnt = 0; hold = 5;
    step(1, 0, 0);
    chk("start_ready", ready, 1);
    post();
    while (idx < exp_q.size() && cyc < LIMIT) begin
      e  = exp_q[idx];
      st = ($urandom_range(99) < stall_pct);
      if (idx == stall_idx && hold > 0) begin
        st = 1'b1;
        hold--;
      end
      sn = noise && ($urandom_range(7) == 0);
      if (idx == abort_idx) begin
        step(0, 1, 0);
        chk("abort_busy", busy, 1);
        post();
        break;
      end
      step(sn, 0, st);
      chk("run_busy", busy, 1);
      chk("run_ra", raddr_a, e.a);
      chk("run_rb", raddr_b, e.b);
      chk("run_lag", lag_idx, e.lag);
      if (st) begin
        chk("stall_vld", mac_valid, 0);
        chk("stall_clr", acc_clr, 0);
        chk("stall_wsel", wsel, 0);
      end else begin
        chk("run_vld", mac_valid, e.vld);
        chk("run_clr", acc_clr, e.clr);
        chk("run_wsel", wsel, e.ws);
        if (e.lag == 3 && e.clr) begin
          chk("lag3_first_a", raddr_a, FULL ? 0 : 3);
          chk("lag3_first_b", raddr_b, 0);
        end
        if (e.lag == 3 && e.ws != 0) begin
          chk("lag3_last_a", raddr_a, FL - 1);
          chk("lag3_last_b", raddr_b, FL - 4);
          chk("lag3_last_wsel", wsel, 8);
        end
        vcnt += mac_valid;
        ccnt += acc_clr;
        wcnt += (wsel != 0);
        idx++;
        act++;
      end
      post();
      cyc++;
    end
    chk("sweep_bound", cyc < LIMIT, 1);
    if (abort_idx >= 0) begin
      for (int i = 0; i < 20; i++) begin
        step(0, 0, 0);
        chk("post_abort_ready", ready, 1);
        chk("post_abort_busy", busy, 0);
        chk("post_abort_done", done, 0);
        chk("post_abort_wsel", wsel, 0);
        post();
      end
    end else begin
      step(0, 0, 1'($urandom_range(1)));
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_ready", ready, 0);
      chk("done_vld", mac_valid, 0);
      chk("done_wsel", wsel, 0);
      post();
      step(0, 0, 0);
      chk("done_cleared", done, 0);
      chk("back_ready", ready, 1);
      post();
      chk("active_cycles", act, lpc_total_cycles(FL, ORD, FULL));
      chk("valid_count", vcnt, valid_total());
      chk("clr_count", ccnt, ORD + 1);
      chk("wsel_count", wcnt, ORD + 1);
    end
  endtask

  initial begin
    int sidx, aidx, sn_n, ab_l, ab_n;
    nvec  = 0;
    nmis  = 0;
    start = 0;
    abort = 0;
    stall = 0;
    reset = 1;
    build_model();

    tv[0]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
    tv[5]  = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0};
    tv[6]  = '{1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0};
    tv[8]  = '{0, 1, 0, 0, 1, 0, 1, 0, 2, 2, 0, 0};
    tv[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    post();
    post();
    step(0, 0, 0);
    chk_idle("reset");
    post();
    reset = 0;

    for (int i = 0; i < 11; i++) begin
      step(tv[i].s, tv[i].ab, tv[i].st);
      chk($sformatf("tv%0d_ready", i), ready, tv[i].rdy);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("tv%0d_done", i), done, tv[i].dn);
      chk($sformatf("tv%0d_vld", i), mac_valid, tv[i].vld);
      chk($sformatf("tv%0d_clr", i), acc_clr, tv[i].clr);
      chk($sformatf("tv%0d_ra", i), raddr_a, tv[i].ra);
      chk($sformatf("tv%0d_rb", i), raddr_b, tv[i].rb);
      chk($sformatf("tv%0d_lag", i), lag_idx, tv[i].lg);
      chk($sformatf("tv%0d_wsel", i), wsel, tv[i].ws);
      post();
    end

    run_sweep(0, 0, -1, -1);

    sn_n = (FL > 60) ? 50 : FL / 2;
    sidx = find_idx(2, sn_n);
    chk("stall_idx_found", sidx >= 0, 1);
    run_sweep(0, 1, sidx, -1);

    ab_l = (ORD >= 4) ? 4 : ORD;
    ab_n = (FL > 103) ? 100 : FL - 3;
    aidx = find_idx(ab_l, ab_n);
    chk("abort_idx_found", aidx >= 0, 1);
    run_sweep(0, 0, -1, aidx);

    run_sweep(25, 1, -1, -1);

    step(1, 0, 0);
    post();
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0);
      post();
    end
    reset = 1;
    step(0, 0, 0);
    post();
    reset = 0;
    step(0, 0, 0);
    chk_idle("midrun_reset");
    post();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      chk("after_reset_done", done, 0);
      chk("after_reset_ready", ready, 1);
      post();
    end

    run_sweep(0, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
